// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares the 4-bit register configuration bus between NREQ requesters.
//   One access at a time: IDLE picks a winner, BUS holds valid until the
//   slave acks or the timeout expires, GAP keeps valid low for one more
//   cycle before the next decision. Every output is registered.
//
//   Build option: define ARB_FIXED_PRIO_EN for fixed-priority arbitration
//   (lowest index wins). Without it, arbitration is round-robin starting
//   after the last granted requester.
//
// Handshake: a requester raises req_valid[i] with its address/data and holds
//   them until it sees req_done[i] or req_fault[i] (one-cycle pulses). The
//   slave side sees valid held high with stable address/data until ack.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/addr/data   per-requester request, 4-bit fields packed by index
//   req_done/req_fault    per-requester completion / timeout pulses
//   rsp_data/_valid       readback captured during the last access
//   grant                 one-hot current owner (0 when idle)
//   busy                  high in BUS and GAP
//   address/data/valid    slave bus request
//   ack/data_out/_valid   ORed slave response
//   fault                 sticky timeout indicator
module reg_bus_arbiter #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [4*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_done,
    output logic [NREQ-1:0]   req_fault,
    output logic [3:0]        rsp_data,
    output logic              rsp_data_valid,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [3:0]        address,
    output logic [3:0]        data,
    output logic              valid,
    input  logic              ack,
    input  logic [3:0]        data_out,
    input  logic              data_out_valid,
    output logic              fault
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last_grant, last_grant_nxt, winner;
    logic [CNT_W-1:0] count, count_nxt;
    logic             captured, captured_nxt;
    logic             timeout_hit;
    logic [3:0]       sel_addr, sel_data;

    logic [NREQ-1:0]  req_done_nxt, req_fault_nxt, grant_nxt;
    logic [3:0]       rsp_data_nxt, address_nxt, data_nxt;
    logic             rsp_data_valid_nxt, busy_nxt, valid_nxt, fault_nxt;

    assign timeout_hit = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Winner selection and request mux.
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner = last_grant;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) winner = IDX_W'(i);
        end
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr = req_addr[4*i +: 4];
                sel_data = req_data[4*i +: 4];
            end
        end
    end
`else
    logic [IDX_W:0] cand;
    logic           found;
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = '0;
        // Walk last_grant+1 .. last_grant+NREQ, wrapping at NREQ.
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
            if (!found && req_valid[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_addr = req_addr[4*i +: 4];
                sel_data = req_data[4*i +: 4];
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = BUS;
            BUS:     if (ack || timeout_hit) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for every registered output and datapath reg.
    always_comb begin
        last_grant_nxt     = last_grant;
        count_nxt          = count;
        captured_nxt       = captured;
        req_done_nxt       = '0;
        req_fault_nxt      = '0;
        rsp_data_nxt       = rsp_data;
        rsp_data_valid_nxt = rsp_data_valid;
        grant_nxt          = grant;
        address_nxt        = address;
        data_nxt           = data;
        valid_nxt          = valid;
        fault_nxt          = fault;
        busy_nxt           = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                grant_nxt = '0;
                if (|req_valid) begin
                    address_nxt    = sel_addr;
                    data_nxt       = sel_data;
                    grant_nxt      = '0;
                    grant_nxt[winner] = 1'b1;
                    valid_nxt      = 1'b1;
                    last_grant_nxt = winner;
                    count_nxt      = '0;
                    captured_nxt   = 1'b0;
                end
            end
            BUS: begin
                count_nxt = count + CNT_W'(1);
                if (data_out_valid) begin
                    rsp_data_nxt = data_out;
                    captured_nxt = 1'b1;
                end
                // Ack has priority over a timeout in the same cycle.
                if (ack) begin
                    valid_nxt                = 1'b0;
                    req_done_nxt[last_grant] = 1'b1;
                    rsp_data_valid_nxt       = captured | data_out_valid;
                end else if (timeout_hit) begin
                    valid_nxt                 = 1'b0;
                    req_fault_nxt[last_grant] = 1'b1;
                    fault_nxt                 = 1'b1;
                    rsp_data_valid_nxt        = 1'b0;
                end
            end
            GAP: begin
                valid_nxt = 1'b0;
                grant_nxt = '0;   // takes effect as the FSM enters IDLE
            end
            default: begin
                valid_nxt = 1'b0;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= IDX_W'(NREQ - 1);
            count          <= '0;
            captured       <= 1'b0;
            req_done       <= '0;
            req_fault      <= '0;
            rsp_data       <= '0;
            rsp_data_valid <= 1'b0;
            grant          <= '0;
            busy           <= 1'b0;
            address        <= '0;
            data           <= '0;
            valid          <= 1'b0;
            fault          <= 1'b0;
        end else begin
            last_grant     <= last_grant_nxt;
            count          <= count_nxt;
            captured       <= captured_nxt;
            req_done       <= req_done_nxt;
            req_fault      <= req_fault_nxt;
            rsp_data       <= rsp_data_nxt;
            rsp_data_valid <= rsp_data_valid_nxt;
            grant          <= grant_nxt;
            busy           <= busy_nxt;
            address        <= address_nxt;
            data           <= data_nxt;
            valid          <= valid_nxt;
            fault          <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter with NREQ=3, TIMEOUT_CYCLES=8.
module tb_reg_bus_arbiter;
    localparam int N     = 3;
    localparam int T     = 8;
    localparam int NOACK = 99;
    localparam int NRAND = 30;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_valid;
    logic [11:0]  req_addr, req_data;
    logic [2:0]   req_done, req_fault, grant;
    logic [3:0]   rsp_data, address, data, data_out;
    logic         rsp_data_valid, busy, valid, ack, data_out_valid, fault;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_done(req_done), .req_fault(req_fault),
        .rsp_data(rsp_data), .rsp_data_valid(rsp_data_valid),
        .grant(grant), .busy(busy),
        .address(address), .data(data), .valid(valid),
        .ack(ack), .data_out(data_out), .data_out_valid(data_out_valid),
        .fault(fault)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_rsp;
    logic       exp_rsp_v;
    logic       exp_fault;
    int         model_last;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [2:0]  reqv;
        logic [11:0] ra;
        logic [11:0] rd;
        int          ack_lat;
        int          dov_at;
        logic [3:0]  dout;
        logic [2:0]  grant;
    } vec_t;
    vec_t vecs[10];

    logic [2:0]  r_reqv[NRAND];
    logic [11:0] r_ra[NRAND], r_rd[NRAND];
    int          r_lat[NRAND], r_dov[NRAND];
    logic [3:0]  r_dout[NRAND];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [2:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Arbitration reference: plain search over requester indices.
    function automatic logic [2:0] model_pick(input logic [2:0] r, input int last);
        logic [2:0] one;
        one = 3'b001;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return one << i;
`else
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (r[j]) return one << j;
        end
`endif
        return 3'b000;
    endfunction

    // Starts in an IDLE cycle (#1 after an edge); ends in the next IDLE cycle.
    task automatic run_access(input logic [2:0] reqv, input logic [11:0] ra,
                              input logic [11:0] rd, input int ack_lat,
                              input int dov_at, input logic [3:0] dout,
                              input logic [2:0] g);
        int   gi, last_c, vhigh;
        logic stable, acked;
        gi = onehot_idx(g);
        req_valid = reqv; req_addr = ra; req_data = rd;
        @(posedge clk); #1;
        chk("launch_valid", valid, 1);
        chk("launch_grant", grant, g);
        chk("launch_addr", address, ra[gi*4 +: 4]);
        chk("launch_data", data, rd[gi*4 +: 4]);
        chk("launch_busy", busy, 1);
        acked  = (ack_lat < T);
        last_c = acked ? ack_lat : T - 1;
        vhigh  = 0;
        stable = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            if (valid) vhigh++;
            if (address !== ra[gi*4 +: 4] || data !== rd[gi*4 +: 4] || grant !== g) stable = 1'b0;
            ack = (c == ack_lat);
            data_out_valid = (c == dov_at);
            data_out = dout;
            if (c == dov_at) exp_rsp = dout;
            @(posedge clk); #1;
        end
        ack = 1'b0; data_out_valid = 1'b0;
        req_valid = 3'b000;
        exp_rsp_v = acked && (dov_at <= last_c);
        if (!acked) exp_fault = 1'b1;
        chk("valid_high_cycles", vhigh, last_c + 1);
        chk("bus_stable", stable, 1);
        chk("gap_valid", valid, 0);
        chk("req_done", req_done, acked ? g : 3'b000);
        chk("req_fault", req_fault, acked ? 3'b000 : g);
        chk("fault", fault, exp_fault);
        chk("rsp_data_valid", rsp_data_valid, exp_rsp_v);
        chk("rsp_data", rsp_data, exp_rsp);
        chk("gap_grant", grant, g);
        chk("gap_busy", busy, 1);
        @(posedge clk); #1;
        chk("idle_valid", valid, 0);
        chk("idle_grant", grant, 0);
        chk("idle_busy", busy, 0);
        chk("idle_pulses", {req_done, req_fault}, 0);
        model_last = gi;
    endtask

    initial begin
        // Directed vectors: {request, stimulus, expected grant}.
        vecs[0] = '{3'b111, 12'h321, 12'h654, 1, NOACK, 4'h0, 3'b001};
        vecs[1] = '{3'b111, 12'h321, 12'h654, 1, NOACK, 4'h0, 3'b010};
        vecs[2] = '{3'b111, 12'h321, 12'h654, 1, NOACK, 4'h0, 3'b100};
        vecs[3] = '{3'b111, 12'h987, 12'hcba, 1, NOACK, 4'h0, 3'b001};
        vecs[4] = '{3'b010, 12'h0a0, 12'h050, 3, 3,     4'hc, 3'b010};
        vecs[5] = '{3'b011, 12'h0b6, 12'h0d2, 7, NOACK, 4'h0, 3'b001};
        vecs[6] = '{3'b001, 12'h004, 12'h008, NOACK, 2, 4'he, 3'b001};
        vecs[7] = '{3'b100, 12'h300, 12'h900, 2, 0,     4'h7, 3'b100};
        vecs[8] = '{3'b110, 12'h4f0, 12'h1e0, 0, 0,     4'h9, 3'b010};
        vecs[9] = '{3'b110, 12'h5a0, 12'h2b0, 0, NOACK, 4'h0, 3'b100};
`ifdef ARB_FIXED_PRIO_EN
        vecs[1].grant = 3'b001;
        vecs[2].grant = 3'b001;
        vecs[3].grant = 3'b001;
        vecs[9].grant = 3'b010;
`endif

        // Clock/reset.
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        ack = 1'b0; data_out = '0; data_out_valid = 1'b0;
        exp_rsp = '0; exp_rsp_v = 1'b0; exp_fault = 1'b0; model_last = N - 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {req_done, req_fault, rsp_data, rsp_data_valid, grant,
                              busy, address, data, valid, fault}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_access(vecs[i].reqv, vecs[i].ra, vecs[i].rd, vecs[i].ack_lat,
                       vecs[i].dov_at, vecs[i].dout, vecs[i].grant);

        // Slave strobes while idle must be ignored.
        ack = 1'b1; data_out_valid = 1'b1; data_out = 4'hf;
        repeat (2) @(posedge clk);
        #1;
        ack = 1'b0; data_out_valid = 1'b0;
        chk("idle_ack_ignored", {req_done, valid, busy}, 0);
        chk("idle_dov_ignored", {rsp_data_valid, rsp_data}, {exp_rsp_v, exp_rsp});

        // Asynchronous reset in the middle of an access.
        req_valid = 3'b100; req_addr = 12'h700; req_data = 12'h100;
        @(posedge clk); #1;
        chk("pre_reset_valid", valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {valid, grant, busy}, 0);
        req_valid = '0;
        @(posedge clk); #1;
        chk("reset_no_pulse", {req_done, req_fault, fault}, 0);
        rst = 1'b0;
        exp_rsp = '0; exp_rsp_v = 1'b0; exp_fault = 1'b0; model_last = N - 1;
        run_access(3'b111, 12'h210, 12'h543, 1, 0, 4'h6, 3'b001);

        // Randomized accesses scored against the arbitration model.
        for (int i = 0; i < NRAND; i++) begin
            r_reqv[i] = 3'($urandom_range(1, 7));
            r_ra[i]   = 12'($urandom);
            r_rd[i]   = 12'($urandom);
            r_lat[i]  = $urandom_range(0, 9);
            if (r_lat[i] >= T) r_lat[i] = NOACK;
            r_dov[i]  = $urandom_range(0, 10);
            r_dout[i] = 4'($urandom);
        end
        begin
            int last;
            last = model_last;
            for (int i = 0; i < NRAND; i++) begin
                logic [2:0] g;
                g = model_pick(r_reqv[i], last);
                exp_q.push_back(g);
                last = onehot_idx(g);
            end
        end
        for (int i = 0; i < NRAND; i++) begin
            logic [2:0] g;
            g = exp_q.pop_front();
            run_access(r_reqv[i], r_ra[i], r_rd[i], r_lat[i], r_dov[i], r_dout[i], g);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
